seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_LEN, default 5: pattern length in bits, legal range 2..8.
REQ-002 Parameter CNT_W, default 16: width of match_cnt.
REQ-003 Port clk, input, 1: single clock; all logic is on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle frame-start pulse, accepted only in IDLE.
REQ-006 Port frame_len, input, 8: number of bytes in the frame, sampled on accepted start.
REQ-007 Port pattern, input, PAT_LEN: target bit pattern, MSB is the oldest bit, sampled on accepted start.
REQ-008 Port s_valid, input, 1: byte-source valid.
REQ-009 Port s_data, input, 8: byte from the source.
REQ-010 Port s_ready, output, 1: byte-sink ready.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port match_pulse, output, 1: one-cycle pulse per pattern hit.
REQ-013 Port match_cnt, output, CNT_W: number of hits in the current or last frame.
REQ-014 Port done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-015 The FSM SHALL be one-hot with four states: IDLE, WAIT_BYTE, SHIFT and DONE.
REQ-016 IDLE SHALL transition as follows:
- start=1 and frame_len!=0: go to WAIT_BYTE.
- start=1 and frame_len==0: go to DONE.
- Otherwise: stay in IDLE.
REQ-017 On an accepted start, the block SHALL:
- latch pattern and frame_len;
- clear match_cnt, the bit history and the valid-bit count (no matches carry across frames).
REQ-018 s_ready SHALL be high only in WAIT_BYTE; a byte is accepted on s_valid && s_ready.
REQ-019 After a byte is accepted, the block SHALL:
- latch the byte and move to SHIFT;
- with s_valid low, stay in WAIT_BYTE indefinitely.
REQ-020 SHIFT SHALL apply one bit per cycle, MSB first, for exactly 8 cycles, using a 3-bit index counter.
REQ-021 The history register SHALL update each SHIFT cycle as hist <= {hist[PAT_LEN-2:0], bit}.
REQ-022 The valid-bit count SHALL increment each SHIFT cycle and saturate at PAT_LEN.
REQ-023 A hit SHALL occur when hist_next == latched pattern and valid-bit count + 1 >= PAT_LEN; overlapping hits SHALL count.
REQ-024 match_pulse SHALL be registered: it is high the cycle after the SHIFT cycle that shifted in the completing bit.
REQ-025 match_cnt SHALL increment in the same cycle match_pulse rises and saturate at all-ones (no wrap).
REQ-026 After the 8th bit, SHIFT SHALL go to DONE if the frame byte counter equals frame_len, else to WAIT_BYTE.
REQ-027 Throughput SHALL be one byte per 9 cycles: a byte accepted at cycle t gives bits at t+1..t+8 and s_ready high again at t+9.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 The final byte's last-bit match_pulse SHALL coincide with done, and match_cnt SHALL be final in that cycle.
REQ-030 match_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-031 start asserted in any state other than IDLE SHALL be ignored.
REQ-032 Changes to pattern or frame_len mid-frame SHALL have no effect.

Reset
REQ-033 While rst=1, the block SHALL:
- enter IDLE;
- drive s_ready=0, busy=0, match_pulse=0, done=0;
- clear match_cnt, history, counters and the latched byte.
REQ-034 rst asserted mid-frame SHALL abort the frame with no done pulse; the first cycle after rst deasserts is IDLE.

Verification
REQ-035 pattern=10010, frame_len=1, byte 0x92 -> match_pulse the cycle after bits 5 and 8 are shifted in; match_cnt=2; done once.
REQ-036 pattern=10010, frame_len=2, bytes 0x09 then 0x00 -> exactly one hit across the byte boundary (bit 9); match_cnt=1.
REQ-037 frame_len=0 with start -> done exactly one cycle after start; s_ready never high; match_cnt=0.
REQ-038 CNT_W=2, pattern=00000, frame_len=2, bytes 0x00 0x00 -> 12 match_pulses; match_cnt saturates at 3.
REQ-039 s_valid held low for 20 cycles in WAIT_BYTE, plus start pulses while busy -> the block stalls with s_ready=1, start is ignored, and the frame completes normally once bytes arrive.
REQ-040 rst asserted during SHIFT of byte 1 of 3 -> next cycle is IDLE with all outputs 0 and no done; a new start runs a clean frame.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector: frame bytes are accepted one at a time and shifted MSB-first
// through a history register compared against a pattern latched at frame start.
module seq_det_ctrl #(
  parameter int PAT_LEN = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         frame_len,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done
);

  // state     | meaning
  // IDLE      | waiting for start; match_cnt holds the last frame's result
  // WAIT_BYTE | s_ready high, waiting for the next source byte
  // SHIFT     | applying the latched byte one bit per cycle, MSB first
  // DONE      | one-cycle end-of-frame pulse
  localparam logic [3:0] IDLE      = 4'b0001;
  localparam logic [3:0] WAIT_BYTE = 4'b0010;
  localparam logic [3:0] SHIFT     = 4'b0100;
  localparam logic [3:0] DONE      = 4'b1000;

  localparam int VC_W = $clog2(PAT_LEN + 1);
  localparam logic [VC_W-1:0] PAT_LEN_V = VC_W'(PAT_LEN);

  logic [3:0]         state, state_nxt;
  logic [PAT_LEN-1:0] pat_q;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [7:0]         len_q;
  logic [7:0]         byte_cnt;
  logic [7:0]         data_q;
  logic [2:0]         bit_idx;
  logic [VC_W-1:0]    vcnt;
  logic               cur_bit;
  logic               hit;

  assign cur_bit  = data_q[3'd7 - bit_idx];
  assign hist_nxt = {hist[PAT_LEN-2:0], cur_bit};

  // vcnt guards against matching on history bits left over from before the frame
  assign hit = (state == SHIFT) && (hist_nxt == pat_q) &&
               (({1'b0, vcnt} + (VC_W+1)'(1)) >= {1'b0, PAT_LEN_V});

  assign s_ready = (state == WAIT_BYTE);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (frame_len == 8'd0) ? DONE : WAIT_BYTE;
      end
      WAIT_BYTE: begin
        if (s_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (bit_idx == 3'd7) state_nxt = (byte_cnt == len_q) ? DONE : WAIT_BYTE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      hist        <= '0;
      vcnt        <= '0;
      byte_cnt    <= '0;
      data_q      <= '0;
      bit_idx     <= '0;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      match_pulse <= hit;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q     <= pattern;
            len_q     <= frame_len;
            hist      <= '0;
            vcnt      <= '0;
            byte_cnt  <= '0;
            match_cnt <= '0;
          end
        end
        WAIT_BYTE: begin
          if (s_valid) begin
            data_q   <= s_data;
            bit_idx  <= '0;
            byte_cnt <= byte_cnt + 8'd1;
          end
        end
        SHIFT: begin
          hist    <= hist_nxt;
          bit_idx <= bit_idx + 3'd1;
          if (vcnt != PAT_LEN_V) vcnt <= vcnt + VC_W'(1);
          if (hit && (match_cnt != {CNT_W{1'b1}})) match_cnt <= match_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed and randomized frames checked every cycle against
// a frame-level model built from bit windows and the one-byte-per-9-cycles timing rule.
module tb_seq_det_ctrl;
  localparam int PL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, s_valid;
  logic [7:0]    frame_len, s_data;
  logic [PL-1:0] pattern;
  logic          s_ready, busy, match_pulse, done;
  logic [15:0]   match_cnt;
  logic          s_ready2, busy2, match_pulse2, done2;
  logic [1:0]    match_cnt2;

  seq_det_ctrl #(.PAT_LEN(PL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .pattern(pattern),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy),
    .match_pulse(match_pulse), .match_cnt(match_cnt), .done(done)
  );

  // narrow-counter copy sees identical stimulus to exercise saturation
  seq_det_ctrl #(.PAT_LEN(PL), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .pattern(pattern),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2), .busy(busy2),
    .match_pulse(match_pulse2), .match_cnt(match_cnt2), .done(done2)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  bit            m_busy;
  int            m_ready_at = -1;
  int            m_done_at = -1;
  int            m_cnt;
  int            m_len;
  int            m_acc;
  logic [PL-1:0] m_pat;
  int            pulse_q[$];
  bit            hbits[$];
  bit            last_acc;
  int            pulses_seen = 0;
  int            dones_seen = 0;
  logic [7:0]    bq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit exp_pulse;
    bit exp_ready;
    bit exp_done;
    int c16;
    int c2;
    exp_pulse = (pulse_q.size() > 0) && (pulse_q[0] == cyc);
    if (exp_pulse) begin
      void'(pulse_q.pop_front());
      m_cnt++;
    end
    exp_ready = (m_ready_at >= 0) && (cyc >= m_ready_at);
    exp_done  = (m_done_at == cyc);
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c2  = (m_cnt > 3) ? 3 : m_cnt;
    chk("s_ready", 32'(s_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("match_pulse", 32'(match_pulse), 32'(exp_pulse));
    chk("done", 32'(done), 32'(exp_done));
    chk("match_cnt", 32'(match_cnt), 32'(c16));
    chk("s_ready_w2", 32'(s_ready2), 32'(exp_ready));
    chk("match_pulse_w2", 32'(match_pulse2), 32'(exp_pulse));
    chk("done_w2", 32'(done2), 32'(exp_done));
    chk("match_cnt_w2", 32'(match_cnt2), 32'(c2));
    if (match_pulse) pulses_seen++;
    if (done) dones_seen++;
  endtask

  function automatic bit window_hit();
    int n;
    n = hbits.size();
    if (n < PL) return 1'b0;
    for (int k = 0; k < PL; k++)
      if (hbits[n-PL+k] != m_pat[PL-1-k]) return 1'b0;
    return 1'b1;
  endfunction

  // check the current cycle, advance the model by what the next edge samples, then move on
  task automatic step();
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    check_cycle();
    if (rst) begin
      m_busy = 1'b0; m_ready_at = -1; m_done_at = -1; m_cnt = 0;
      pulse_q.delete(); hbits.delete();
    end else if (!m_busy && start) begin
      m_busy = 1'b1; m_pat = pattern; m_len = int'(frame_len); m_acc = 0; m_cnt = 0;
      hbits.delete();
      if (frame_len == 8'd0) m_done_at = cyc + 1;
      else m_ready_at = cyc + 1;
    end else if ((m_ready_at >= 0) && (cyc >= m_ready_at) && s_valid) begin
      acc = 1'b1;
      m_acc++;
      for (int j = 0; j < 8; j++) begin
        hbits.push_back(s_data[7-j]);
        if (window_hit()) pulse_q.push_back(cyc + 2 + j);
      end
      if (m_acc == m_len) begin
        m_ready_at = -1;
        m_done_at = cyc + 9;
      end else begin
        m_ready_at = cyc + 9;
      end
    end else if (m_done_at == cyc) begin
      m_busy = 1'b0;
      m_done_at = -1;
    end
    last_acc = acc;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_frame(input logic [PL-1:0] pat, input int len, input int min_gap,
                           input int max_gap, input bit noise, input int abort_cyc);
    int bi;
    int gap;
    int t0;
    int d0;
    bi = 0;
    t0 = cyc;
    d0 = dones_seen;
    pattern = pat; frame_len = 8'(len); start = 1'b1; s_valid = 1'b0;
    step();
    start = 1'b0;
    gap = $urandom_range(max_gap, min_gap);
    while (m_busy) begin
      if (cyc - t0 > 5000) begin
        compared++; mismatched++;
        $display("FAIL frame_timeout observed=busy expected=idle cycle=%0d", cyc);
        break;
      end
      if ((abort_cyc >= 0) && (cyc - t0 == abort_cyc)) begin
        rst = 1'b1; s_valid = 1'b0;
        step();
        rst = 1'b0;
        break;
      end
      s_valid = (bi < len) && (gap == 0);
      s_data  = (bi < len) ? bq[bi] : 8'($urandom);
      if (noise) begin
        start = 1'($urandom_range(1, 0));
        pattern = PL'($urandom);
        frame_len = 8'($urandom);
      end
      step();
      start = 1'b0;
      if (last_acc) begin
        bi++;
        gap = $urandom_range(max_gap, min_gap);
      end else if (gap > 0) begin
        gap--;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    step();
    if (abort_cyc < 0) chk("done_once", 32'(dones_seen - d0), 32'd1);
    else chk("no_done_on_abort", 32'(dones_seen - d0), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished cycle=%0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int p0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; frame_len = '0; pattern = '0;
    @(posedge clk); #1;
    step();
    step();
    rst = 1'b0;
    step();

    // single byte, two overlapping-window hits at bits 5 and 8
    bq.delete(); bq.push_back(8'h92);
    p0 = pulses_seen;
    run_frame(5'b10010, 1, 0, 0, 1'b0, -1);
    chk("t035_cnt", 32'(match_cnt), 32'd2);
    chk("t035_pulses", 32'(pulses_seen - p0), 32'd2);

    // hit straddling the byte boundary
    bq.delete(); bq.push_back(8'h09); bq.push_back(8'h00);
    p0 = pulses_seen;
    run_frame(5'b10010, 2, 0, 3, 1'b0, -1);
    chk("t036_cnt", 32'(match_cnt), 32'd1);
    chk("t036_pulses", 32'(pulses_seen - p0), 32'd1);

    // empty frame
    bq.delete();
    run_frame(5'b10101, 0, 0, 0, 1'b0, -1);
    chk("t037_cnt", 32'(match_cnt), 32'd0);

    // every window from bit 5 on matches; narrow counter saturates
    bq.delete(); bq.push_back(8'h00); bq.push_back(8'h00);
    p0 = pulses_seen;
    run_frame(5'b00000, 2, 0, 0, 1'b0, -1);
    chk("t038_pulses", 32'(pulses_seen - p0), 32'd12);
    chk("t038_cnt16", 32'(match_cnt), 32'd12);
    chk("t038_cnt2", 32'(match_cnt2), 32'd3);

    // count holds across idle cycles
    repeat (5) step();
    chk("idle_hold", 32'(match_cnt), 32'd12);

    // long stalls in WAIT_BYTE with start and config noise while busy
    bq.delete(); bq.push_back(8'h92); bq.push_back(8'h49); bq.push_back(8'h24);
    run_frame(5'b10010, 3, 30, 30, 1'b1, -1);

    // reset during SHIFT of the first of three bytes, then a clean frame
    bq.delete(); bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'h00);
    run_frame(5'b00000, 3, 0, 0, 1'b0, 4);
    chk("t040_cnt_cleared", 32'(match_cnt), 32'd0);
    bq.delete(); bq.push_back(8'h92);
    run_frame(5'b10010, 1, 0, 0, 1'b0, -1);
    chk("t040_clean_cnt", 32'(match_cnt), 32'd2);

    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(4, 1);
      bq.delete();
      for (int b = 0; b < len; b++)
        bq.push_back(($urandom_range(3, 0) == 0) ? 8'h92 : 8'($urandom));
      run_frame(PL'($urandom), len, 0, 4, 1'($urandom_range(1, 0)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
